// File: rtl/spn_iter_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spn_iter_core : iterative nibble SPN block cipher, one round per cycle     |
// | Revision      : 1.0                                                       |
// +----------------------------------------------------------------------------+
module spn_iter_core #(
  parameter int DATA_W = 16,
  parameter int KEY_W  = 32,
  parameter int ROUNDS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        opcode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEY_W-1:0]  key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        valid,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] c_OP_NOP = 2'b00;
  localparam logic [1:0] c_OP_ENC = 2'b01;
  localparam logic [1:0] c_OP_ILL = 2'b11;
  localparam int         c_NIB    = DATA_W / 4;
  localparam logic [3:0] c_LAST   = 4'(ROUNDS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_round;
  logic [DATA_W-1:0]   r_st;
  logic [DATA_W-1:0]   r_out_data;
  logic [KEY_W-1:0]    r_key;
  logic [1:0]          r_op;
  logic [1:0]          r_valid;
  logic                r_out_valid;

  logic                w_accept;
  logic                w_last;
  logic [31:0]         w_rk_idx;
  logic [DATA_W-1:0]   w_rk;
  logic [DATA_W-1:0]   w_sub;
  logic [DATA_W-1:0]   w_dec_p;
  logic [DATA_W-1:0]   w_inv;
  logic [DATA_W-1:0]   w_enc_nxt;
  logic [DATA_W-1:0]   w_dec_nxt;
  logic [DATA_W-1:0]   w_step_nxt;

  function automatic logic [3:0] f_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hE;  4'h1: return 4'h4;  4'h2: return 4'hD;  4'h3: return 4'h1;
      4'h4: return 4'h2;  4'h5: return 4'hF;  4'h6: return 4'hB;  4'h7: return 4'h8;
      4'h8: return 4'h3;  4'h9: return 4'hA;  4'hA: return 4'h6;  4'hB: return 4'hC;
      4'hC: return 4'h5;  4'hD: return 4'h9;  4'hE: return 4'h0;  default: return 4'h7;
    endcase
  endfunction

  function automatic logic [3:0] f_sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: return 4'hE;  4'h1: return 4'h3;  4'h2: return 4'h4;  4'h3: return 4'h8;
      4'h4: return 4'h1;  4'h5: return 4'hC;  4'h6: return 4'hA;  4'h7: return 4'hF;
      4'h8: return 4'h7;  4'h9: return 4'hD;  4'hA: return 4'h9;  4'hB: return 4'h6;
      4'hC: return 4'hB;  4'hD: return 4'h2;  4'hE: return 4'h0;  default: return 4'h5;
    endcase
  endfunction

  // Round key r: key rotated left by 4*r (mod KEY_W), truncated to the block width.
  function automatic logic [DATA_W-1:0] f_round_key(input logic [KEY_W-1:0] k,
                                                    input logic [31:0]      r);
    logic [31:0]      amt;
    logic [KEY_W-1:0] rot;
    amt = (r * 32'd4) % 32'(KEY_W);
    rot = (k << amt) | (k >> (32'(KEY_W) - amt));
    return rot[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] f_rotl3(input logic [DATA_W-1:0] x);
    return {x[DATA_W-4:0], x[DATA_W-1:DATA_W-3]};
  endfunction

  function automatic logic [DATA_W-1:0] f_rotr3(input logic [DATA_W-1:0] x);
    return {x[2:0], x[DATA_W-1:3]};
  endfunction

  assign w_accept = (r_state == S_IDLE) && in_valid && (opcode != c_OP_NOP);
  assign w_last   = (r_round == c_LAST);

  // Decrypt walks the round keys downward while the step counter still counts up.
  assign w_rk_idx = (r_op == c_OP_ENC) ? (32'(r_round) + 32'd1)
                                       : (32'(ROUNDS - 1) - 32'(r_round));
  assign w_rk     = f_round_key(r_key, w_rk_idx);
  assign w_dec_p  = (r_round == 4'd0) ? r_st : f_rotr3(r_st);

  for (genvar n = 0; n < c_NIB; n++) begin : g_nib
    assign w_sub[4*n +: 4] = f_sbox(r_st[4*n +: 4]);
    assign w_inv[4*n +: 4] = f_sbox_inv(w_dec_p[4*n +: 4]);
  end

  assign w_enc_nxt  = (w_last ? w_sub : f_rotl3(w_sub)) ^ w_rk;
  assign w_dec_nxt  = w_inv ^ w_rk;
  assign w_step_nxt = (r_op == c_OP_ENC) ? w_enc_nxt : w_dec_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (opcode == c_OP_ILL) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_round     <= 4'd0;
      r_st        <= '0;
      r_out_data  <= '0;
      r_key       <= '0;
      r_op        <= 2'b00;
      r_valid     <= 2'b00;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_key   <= key;
            r_op    <= opcode;
            r_round <= 4'd0;
            if (opcode == c_OP_ILL) begin
              r_st        <= '0;
              r_out_data  <= '0;
              r_out_valid <= 1'b1;
              r_valid     <= c_OP_ILL;
            end else if (opcode == c_OP_ENC) begin
              r_st <= in_data ^ f_round_key(key, 32'd0);
            end else begin
              r_st <= in_data ^ f_round_key(key, 32'(ROUNDS));
            end
          end
        end
        S_RUN: begin
          r_st    <= w_step_nxt;
          r_round <= r_round + 4'd1;
          if (w_last) begin
            r_out_data  <= w_step_nxt;
            r_out_valid <= 1'b1;
            r_valid     <= r_op;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_valid     <= 2'b00;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_valid     <= 2'b00;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign valid     = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_spn_iter_core.sv
`default_nettype none
// Bench for spn_iter_core: four parameterisations driven from shared buses,
// results compared against a plain-arithmetic cipher model.
module tb_spn_iter_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  inv;
  logic [1:0]  opcode;
  logic [63:0] din;
  logic [63:0] kin;
  logic        out_ready;
  logic [3:0]  rdy;
  logic [3:0]  ov;
  logic [3:0]  bsy;
  logic [1:0]  vl [4];
  logic [15:0] od0;
  logic [15:0] od1;
  logic [7:0]  od2;
  logic [31:0] od3;
  logic [3:0]  sb_t  [16];
  logic [3:0]  sbi_t [16];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  spn_iter_core #(.DATA_W(16), .KEY_W(32), .ROUNDS(3)) dut0 (
    .clk(clk), .reset(reset), .in_valid(inv[0]), .in_ready(rdy[0]), .opcode(opcode),
    .in_data(din[15:0]), .key(kin[31:0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od0), .valid(vl[0]), .busy(bsy[0]));

  spn_iter_core #(.DATA_W(16), .KEY_W(32), .ROUNDS(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(inv[1]), .in_ready(rdy[1]), .opcode(opcode),
    .in_data(din[15:0]), .key(kin[31:0]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od1), .valid(vl[1]), .busy(bsy[1]));

  spn_iter_core #(.DATA_W(8), .KEY_W(16), .ROUNDS(1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(inv[2]), .in_ready(rdy[2]), .opcode(opcode),
    .in_data(din[7:0]), .key(kin[15:0]), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od2), .valid(vl[2]), .busy(bsy[2]));

  spn_iter_core #(.DATA_W(32), .KEY_W(64), .ROUNDS(15)) dut3 (
    .clk(clk), .reset(reset), .in_valid(inv[3]), .in_ready(rdy[3]), .opcode(opcode),
    .in_data(din[31:0]), .key(kin[63:0]), .out_valid(ov[3]), .out_ready(out_ready),
    .out_data(od3), .valid(vl[3]), .busy(bsy[3]));

  function automatic int dw_of(input int i);
    case (i)
      0: return 16;
      1: return 16;
      2: return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int kw_of(input int i);
    case (i)
      0: return 32;
      1: return 32;
      2: return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int r_of(input int i);
    case (i)
      0: return 3;
      1: return 1;
      2: return 1;
      default: return 15;
    endcase
  endfunction

  function automatic logic [63:0] get_od(input int i);
    case (i)
      0: return {48'd0, od0};
      1: return {48'd0, od1};
      2: return {56'd0, od2};
      default: return {32'd0, od3};
    endcase
  endfunction

  function automatic logic [63:0] mask(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] x, input int n, input int w);
    logic [63:0] y;
    y = x & mask(w);
    if (n == 0) return y;
    return ((y << n) | (y >> (w - n))) & mask(w);
  endfunction

  function automatic logic [63:0] sub(input logic [63:0] x, input int w, input bit inverse);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < w / 4; n++) begin
      y[4*n +: 4] = inverse ? sbi_t[x[4*n +: 4]] : sb_t[x[4*n +: 4]];
    end
    return y;
  endfunction

  function automatic logic [63:0] rk(input logic [63:0] k, input int r, input int dw, input int kw);
    return rotl(k, (4 * r) % kw, kw) & mask(dw);
  endfunction

  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] d,
                                        input logic [63:0] k, input int i);
    int          dw;
    int          kw;
    int          nr;
    logic [63:0] st;
    dw = dw_of(i);
    kw = kw_of(i);
    nr = r_of(i);
    if (op == 2'b11) return 64'd0;
    d = d & mask(dw);
    k = k & mask(kw);
    if (op == 2'b01) begin
      st = d ^ rk(k, 0, dw, kw);
      for (int r = 0; r < nr; r++) begin
        st = sub(st, dw, 1'b0);
        if (r != nr - 1) st = rotl(st, 3, dw);
        st = st ^ rk(k, r + 1, dw, kw);
      end
    end else begin
      st = d ^ rk(k, nr, dw, kw);
      for (int r = nr - 1; r >= 0; r--) begin
        if (r != nr - 1) st = rotl(st, dw - 3, dw);
        st = sub(st, dw, 1'b1);
        st = st ^ rk(k, r, dw, kw);
      end
    end
    return st;
  endfunction

  // Present one request to instance i, wait for its result, then retire it.
  task automatic run_txn(input int i, input logic [1:0] op, input logic [63:0] d,
                         input logic [63:0] k, output logic [63:0] got,
                         output logic [1:0] gv, output int lat);
    @(posedge clk); #1;
    opcode = op; din = d; kin = k; inv[i] = 1'b1;
    @(posedge clk); #1;
    inv[i] = 1'b0;
    opcode = 2'b00; din = {$urandom, $urandom}; kin = {$urandom, $urandom};
    lat = 0;
    while (!ov[i] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = get_od(i);
    gv  = vl[i];
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; inv = '0; opcode = 2'b00; din = '0; kin = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({ov[i], vl[i], bsy[i], rdy[i]} !== 5'b0 || get_od(i) !== 64'd0) begin
        $display("FAIL reset_state dut%0d: ov=%b valid=%b busy=%b rdy=%b od=%h, want all 0",
                 i, ov[i], vl[i], bsy[i], rdy[i], get_od(i));
      end else n_pass++;
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (rdy !== 4'hF || bsy !== 4'h0) $display("FAIL reset_release: rdy=%b busy=%b, want 1111/0000", rdy, bsy);
    else n_pass++;
  endtask

  task automatic test_known_vectors();
    logic [63:0] got;
    logic [1:0]  gv;
    int          lat;
    run_txn(0, 2'b01, 64'h0, 64'h0, got, gv, lat);
    n_checks++;
    if (got !== 64'h2222 || gv !== 2'b01 || lat !== 3)
      $display("FAIL known_enc: data=%h valid=%b lat=%0d, want 2222/01/3", got, gv, lat);
    else n_pass++;
    run_txn(0, 2'b10, 64'h2222, 64'h0, got, gv, lat);
    n_checks++;
    if (got !== 64'h0 || gv !== 2'b10 || lat !== 3)
      $display("FAIL known_dec: data=%h valid=%b lat=%0d, want 0000/10/3", got, gv, lat);
    else n_pass++;
    run_txn(1, 2'b01, 64'h0, 64'h0, got, gv, lat);
    n_checks++;
    if (got !== 64'hEEEE || gv !== 2'b01 || lat !== 1)
      $display("FAIL known_r1: data=%h valid=%b lat=%0d, want EEEE/01/1", got, gv, lat);
    else n_pass++;
  endtask

  task automatic test_roundtrip();
    logic [63:0] d, k, ct, pt, exp_ct;
    logic [1:0]  gv;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      repeat (3) begin
        d = {$urandom, $urandom} & mask(dw_of(i));
        k = {$urandom, $urandom} & mask(kw_of(i));
        exp_ct = model(2'b01, d, k, i);
        run_txn(i, 2'b01, d, k, ct, gv, lat);
        n_checks++;
        if (ct !== exp_ct || gv !== 2'b01 || lat !== r_of(i))
          $display("FAIL rt_enc dut%0d: data=%h valid=%b lat=%0d, want %h/01/%0d", i, ct, gv, lat, exp_ct, r_of(i));
        else n_pass++;
        n_checks++;
        if (ov[i] !== 1'b0 || vl[i] !== 2'b00 || get_od(i) !== ct)
          $display("FAIL rt_release dut%0d: ov=%b valid=%b od=%h, want 0/00/%h", i, ov[i], vl[i], get_od(i), ct);
        else n_pass++;
        run_txn(i, 2'b10, ct, k, pt, gv, lat);
        n_checks++;
        if (pt !== d || gv !== 2'b10 || lat !== r_of(i))
          $display("FAIL rt_dec dut%0d: data=%h valid=%b lat=%0d, want %h/10/%0d", i, pt, gv, lat, d, r_of(i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_illegal_and_noop();
    logic [63:0] got;
    logic [1:0]  gv;
    int          lat;
    run_txn(0, 2'b11, {$urandom, $urandom}, {$urandom, $urandom}, got, gv, lat);
    n_checks++;
    if (got !== 64'h0 || gv !== 2'b11 || lat !== 0)
      $display("FAIL illegal: data=%h valid=%b extra_lat=%0d, want 0/11/0", got, gv, lat);
    else n_pass++;
    @(posedge clk); #1;
    opcode = 2'b00; din = 64'h1234; inv[0] = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || ov[0] !== 1'b0)
        $display("FAIL noop: rdy=%b busy=%b ov=%b, want 1/0/0", rdy[0], bsy[0], ov[0]);
      else n_pass++;
    end
    inv[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] d1, k1, d2, k2, exp1, exp2;
    int          n;
    d1 = {48'd0, 16'($urandom)}; k1 = {32'd0, $urandom};
    exp1 = model(2'b01, d1, k1, 0);
    @(posedge clk); #1;
    opcode = 2'b01; din = d1; kin = k1; inv[0] = 1'b1;
    @(posedge clk); #1;
    opcode = 2'b10; din = {$urandom, $urandom}; kin = {$urandom, $urandom};
    n = 0;
    while (!ov[0] && n < 40) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (ov[0] !== 1'b1 || get_od(0) !== exp1 || vl[0] !== 2'b01)
      $display("FAIL b2b_first: ov=%b data=%h valid=%b, want 1/%h/01", ov[0], get_od(0), vl[0], exp1);
    else n_pass++;
    repeat (5) begin
      din = {$urandom, $urandom}; kin = {$urandom, $urandom};
      @(posedge clk); #1;
      n_checks++;
      if (ov[0] !== 1'b1 || get_od(0) !== exp1 || vl[0] !== 2'b01 || rdy[0] !== 1'b0)
        $display("FAIL b2b_hold: ov=%b data=%h valid=%b rdy=%b, want 1/%h/01/0", ov[0], get_od(0), vl[0], rdy[0], exp1);
      else n_pass++;
    end
    d2 = {48'd0, 16'($urandom)}; k2 = {32'd0, $urandom};
    din = d2; kin = k2; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (ov[0] !== 1'b0 || vl[0] !== 2'b00 || rdy[0] !== 1'b1 || get_od(0) !== exp1)
      $display("FAIL b2b_retire: ov=%b valid=%b rdy=%b data=%h, want 0/00/1/%h", ov[0], vl[0], rdy[0], get_od(0), exp1);
    else n_pass++;
    @(posedge clk); #1;
    inv[0] = 1'b0;
    n_checks++;
    if (bsy[0] !== 1'b1 || rdy[0] !== 1'b0)
      $display("FAIL b2b_accept2: busy=%b rdy=%b, want 1/0", bsy[0], rdy[0]);
    else n_pass++;
    exp2 = model(2'b10, d2, k2, 0);
    opcode = 2'b00; din = '0; kin = '0;
    n = 0;
    while (!ov[0] && n < 40) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (get_od(0) !== exp2 || vl[0] !== 2'b10 || n !== 3)
      $display("FAIL b2b_second: data=%h valid=%b lat=%0d, want %h/10/3", get_od(0), vl[0], n, exp2);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] d, k, got, exp_v;
    logic [1:0]  gv;
    int          lat;
    bit          seen;
    @(posedge clk); #1;
    opcode = 2'b01; din = {$urandom, $urandom}; kin = {$urandom, $urandom}; inv[0] = 1'b1;
    @(posedge clk); #1;
    inv[0] = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (ov[0] !== 1'b0 || get_od(0) !== 64'd0 || vl[0] !== 2'b00 || bsy[0] !== 1'b0 || rdy[0] !== 1'b0)
      $display("FAIL reset_mid_run: ov=%b od=%h valid=%b busy=%b rdy=%b, want all 0", ov[0], get_od(0), vl[0], bsy[0], rdy[0]);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ov[0] || bsy[0]) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL reset_abort: result or busy seen after abort=%b, want 0", seen);
    else n_pass++;
    d = {48'd0, 16'($urandom)}; k = {32'd0, $urandom};
    exp_v = model(2'b01, d, k, 0);
    run_txn(0, 2'b01, d, k, got, gv, lat);
    n_checks++;
    if (got !== exp_v || gv !== 2'b01 || lat !== 3)
      $display("FAIL reset_fresh: data=%h valid=%b lat=%0d, want %h/01/3", got, gv, lat, exp_v);
    else n_pass++;
  endtask

  initial begin
    sb_t  = '{4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
              4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7};
    sbi_t = '{4'hE, 4'h3, 4'h4, 4'h8, 4'h1, 4'hC, 4'hA, 4'hF,
              4'h7, 4'hD, 4'h9, 4'h6, 4'hB, 4'h2, 4'h0, 4'h5};
    test_reset();
    test_known_vectors();
    test_roundtrip();
    test_illegal_and_noop();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spn_iter_core.md
SPN_ITER_CORE -- requirements
Module: spn_iter_core

Interface
REQ-001 Parameter DATA_W, default 16, block width in bits; multiple of 4, range 8..64.
REQ-002 Parameter KEY_W, default 32, key width in bits; KEY_W >= DATA_W.
REQ-003 Parameter ROUNDS, default 3, SPN round count; range 1..15.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Port list SHALL be:
  clk        in   1        rising-edge clock
  reset      in   1        asynchronous active-high reset
  in_valid   in   1        request present
  in_ready   out  1        core can accept a request
  opcode     in   2        00 no-op, 01 encrypt, 10 decrypt, 11 illegal
  in_data    in   DATA_W   plaintext or ciphertext
  key        in   KEY_W    cipher key
  out_valid  out  1        result present
  out_ready  in   1        consumer accepts result
  out_data   out  DATA_W   result block
  valid      out  2        result status: 01 encrypted, 10 decrypted, 11 error, 00 none
  busy       out  1        request in flight (RUN or DONE)

Function
REQ-006 FSM states SHALL be IDLE, RUN and DONE; in_ready = (state==IDLE) and reset low.
REQ-007 Acceptance SHALL occur on a rising edge with in_valid=1, in_ready=1 and opcode!=00; opcode 00 is ignored and state stays IDLE.
REQ-008 At acceptance, key and opcode SHALL be captured; later changes to key, opcode or in_data have no effect on the transaction in flight.
REQ-009 Round key k_r (r=0..ROUNDS) SHALL be the low DATA_W bits of the captured key rotated left by 4*r bits, rotation modulo KEY_W.
REQ-010 S is the nibble-wise S-box 0..F -> E,4,D,1,2,F,B,8,3,A,6,C,5,9,0,7; S^-1 is 0..F -> E,3,4,8,1,C,A,F,7,D,9,6,B,2,0,5.
REQ-011 P is rotate-left of DATA_W by 3 bits; P^-1 is rotate-right by 3 bits.
REQ-012 Encrypt: on acceptance, st = in_data ^ k_0 and go to RUN; in RUN step r = 0..ROUNDS-1, one step per cycle: st = P(S(st)) ^ k_(r+1), with P omitted when r = ROUNDS-1.
REQ-013 Decrypt: on acceptance, st = in_data ^ k_ROUNDS; in RUN step r = ROUNDS-1 down to 0: st = S^-1(P^-1(st)) ^ k_r, with P^-1 omitted when r = ROUNDS-1.
REQ-014 A round counter SHALL sequence the steps; the last step's edge SHALL move to DONE. out_valid rises exactly ROUNDS edges after the acceptance edge.
REQ-015 Illegal opcode 11: the acceptance edge SHALL go directly to DONE with out_data=0 and valid=11 (latency 1 edge).
REQ-016 In DONE: out_valid=1, out_data=st, valid=01/10 per captured opcode; these SHALL stay stable while out_ready=0.
REQ-017 DONE with out_ready=1 on an edge SHALL return to IDLE and clear out_valid and valid to 00; out_data holds its last value.
REQ-018 in_ready is 0 in RUN and DONE; requests presented then are not consumed, and in_valid may stay high until accepted.
REQ-019 out_ready in IDLE or RUN SHALL have no effect.
REQ-020 busy = (state != IDLE).

Reset
REQ-021 When reset is asserted, asynchronously: state=IDLE, round counter=0, st=0, out_data=0, out_valid=0, valid=00, busy=0, in_ready=0, captured key/opcode=0.
REQ-022 Reset asserted mid-RUN or in DONE SHALL abort the transaction with no result emitted; the first acceptance after deassertion is a fresh transaction.

Verification
REQ-023 Defaults, key=0, opcode=01, in_data=0x0000 -> out_valid 3 edges after acceptance, out_data=0x2222, valid=01.
REQ-024 Defaults, key=0, opcode=10, in_data=0x2222 -> out_data=0x0000, valid=10; ROUNDS=1, key=0, encrypt 0x0000 -> 0xEEEE after 1 edge.
REQ-025 Random key and data, encrypt then decrypt the result, for {DATA_W,KEY_W,ROUNDS} = {16,32,3}, {8,16,1}, {32,64,15} -> decrypt output equals the original in_data.
REQ-026 opcode=11 -> out_valid 1 edge later with out_data=0, valid=11; opcode=00 with in_valid=1 -> in_ready stays 1, no output.
REQ-027 out_ready held 0 for 5 cycles in DONE, with key and in_data toggling and a second in_valid pending -> outputs stable, in_ready=0; the second request is accepted the cycle after out_ready=1.
REQ-028 Reset pulse at RUN step 1 -> all outputs 0 immediately; no out_valid for the aborted request; the next request completes with correct latency.
